ec_out_packer: RTL and testbench

- Sits directly downstream of the layer-3 encoder controller/PE array.
- Collects the N_PE pooled binary activations emitted per pe_en beat and packs them into full D_OUT-bit output pixels.
- Buffers completed pixels in a small FIFO and streams them to the next layer over a valid/ready handshake.
- Tracks the output row/column position and flags frame completion.

---
 rtl/ec_pkg.sv | 20 ++
 rtl/ec_pix_fifo.sv | 54 +++++
 rtl/ec_out_packer.sv | 156 +++++++++++++++
 tb/tb_ec_out_packer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/ec_pkg.sv
// Shared types and sizing helpers for the layer-3 encoder output packer.
// Holds the packer FSM states and index-width / beats-per-pixel helpers.
package ec_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } ec_pack_state_t;

  function automatic int beats_per_pix(input int d_out, input int n_pe);
    return d_out / n_pe;
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ec_pix_fifo.sv
// Synchronous FIFO for completed pixels ({row, col, data} records).
// Ports: push/wdata/full in, pop/rdata/valid out; rdata is 0 when empty.
module ec_pix_fifo
  import ec_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             valid
);

  localparam int AW = idx_w(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             empty;
  logic             do_pop;
  logic             do_push;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A pop frees a slot in the same cycle, so a push into a full
  // FIFO is allowed when it coincides with a pop.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign valid = !empty;
  assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/ec_out_packer.sv
// Packs N_PE-bit PE beats into D_OUT-bit pixels, buffers and streams them.
// Ports: start/pe_en/pe_out/in_ready upstream; pix_* valid/ready downstream;
// busy/frame_done status. EC_OUT_PACKER_STATUS_EN adds ovf and drop_cnt.
module ec_out_packer
  import ec_pkg::*;
#(
  parameter int H_OUT      = 4,
  parameter int W_OUT      = 16,
  parameter int D_OUT      = 512,
  parameter int N_PE       = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      pe_en,
  input  logic [N_PE-1:0]           pe_out,
  output logic                      in_ready,
  output logic                      pix_valid,
  output logic [D_OUT-1:0]          pix_data,
  output logic [idx_w(H_OUT)-1:0]   pix_row,
  output logic [idx_w(W_OUT)-1:0]   pix_col,
  input  logic                      pix_ready,
  output logic                      busy,
  output logic                      frame_done
`ifdef EC_OUT_PACKER_STATUS_EN
  ,
  output logic                      ovf,
  output logic [15:0]               drop_cnt
`endif
);

  localparam int BEATS = beats_per_pix(D_OUT, N_PE);
  localparam int BW    = idx_w(BEATS);
  localparam int RW    = idx_w(H_OUT);
  localparam int CW    = idx_w(W_OUT);
  localparam int FW    = RW + CW + D_OUT;

  localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(H_OUT - 1);
  localparam logic [CW-1:0] COL_LAST  = CW'(W_OUT - 1);

  ec_pack_state_t state;
  ec_pack_state_t state_nxt;

  logic [BW-1:0]    beat;
  logic [RW-1:0]    row;
  logic [CW-1:0]    col;
  logic [D_OUT-1:0] pack;
  logic [D_OUT-1:0] word;
  logic             fifo_full;
  logic             accept;
  logic             last_beat;
  logic             last_pix;
  logic             push;
  logic             pop;
  logic             go;

  assign go        = (state == IDLE) && start;
  assign in_ready  = (state == RUN) && !fifo_full;
  assign accept    = pe_en && in_ready;
  assign last_beat = (beat == BEAT_LAST);
  assign last_pix  = (row == ROW_LAST) && (col == COL_LAST);
  assign push      = accept && last_beat;
  assign pop       = pix_valid && pix_ready;
  assign busy      = (state != IDLE);

  // Current beat merged in combinationally so the last beat's bits
  // reach the FIFO in the same cycle they arrive.
  always_comb begin
    word = pack;
    word[int'(beat)*N_PE +: N_PE] = pe_out;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    frame_done = 1'b0;
    unique case (state)
      IDLE:  if (start) state_nxt = RUN;
      RUN:   if (push && last_pix) state_nxt = DRAIN;
      DRAIN: if (!pix_valid) state_nxt = DONE;
      DONE: begin
        frame_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat <= '0;
      row  <= '0;
      col  <= '0;
      pack <= '0;
    end else if (go) begin
      beat <= '0;
      row  <= '0;
      col  <= '0;
      pack <= '0;
    end else if (accept) begin
      if (last_beat) begin
        beat <= '0;
        pack <= '0;
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end else begin
        beat <= beat + 1'b1;
        pack <= word;
      end
    end
  end

  ec_pix_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({row, col, word}),
    .full  (fifo_full),
    .pop   (pop),
    .rdata ({pix_row, pix_col, pix_data}),
    .valid (pix_valid)
  );

`ifdef EC_OUT_PACKER_STATUS_EN
  logic drop;

  assign drop = (state == RUN) && pe_en && !in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else if (go) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      ovf <= 1'b1;
      if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ec_out_packer.sv
// Directed bench for ec_out_packer (H_OUT=2, W_OUT=2, D_OUT=8, N_PE=2,
// FIFO_DEPTH=2): vector table for a full frame plus corner sequences.
module tb_ec_out_packer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       pe_en;
  logic [1:0] pe_out;
  logic       in_ready;
  logic       pix_valid;
  logic [7:0] pix_data;
  logic       pix_row;
  logic       pix_col;
  logic       pix_ready;
  logic       busy;
  logic       frame_done;
`ifdef EC_OUT_PACKER_STATUS_EN
  logic        ovf;
  logic [15:0] drop_cnt;
`endif

  int checks = 0;
  int errors = 0;

  ec_out_packer #(
    .H_OUT(2), .W_OUT(2), .D_OUT(8), .N_PE(2), .FIFO_DEPTH(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pe_en      (pe_en),
    .pe_out     (pe_out),
    .in_ready   (in_ready),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .pix_row    (pix_row),
    .pix_col    (pix_col),
    .pix_ready  (pix_ready),
    .busy       (busy),
    .frame_done (frame_done)
`ifdef EC_OUT_PACKER_STATUS_EN
    ,
    .ovf        (ovf),
    .drop_cnt   (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [1:0]  po;
    logic        rdy;
    logic        st;
    logic [31:0] exp;
  } vec_t;

  vec_t       tv [20];
  logic [1:0] pin [4][4];
  logic [7:0] pexp [4];

  function automatic logic [31:0] eo(input logic ir, input logic pv,
                                     input logic [7:0] d, input logic r,
                                     input logic c, input logic b,
                                     input logic fd);
    return {18'b0, ir, pv, d, r, c, b, fd};
  endfunction

  function automatic logic [31:0] outs();
    return {18'b0, in_ready, pix_valid, pix_data, pix_row, pix_col,
            busy, frame_done};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic en, input logic [1:0] po,
                      input logic rdy, input logic st);
    pe_en     = en;
    pe_out    = po;
    pix_ready = rdy;
    start     = st;
    @(posedge clk);
    #1;
    start = 1'b0;
    pe_en = 1'b0;
  endtask

  task automatic async_reset(input string nm);
    #2 rst = 1'b0;
    #1 chk(nm, outs(), eo(0, 0, 8'h00, 0, 0, 0, 0));
    #2 rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    pin  = '{'{2'b01, 2'b10, 2'b11, 2'b00},
             '{2'b11, 2'b11, 2'b00, 2'b01},
             '{2'b10, 2'b01, 2'b10, 2'b01},
             '{2'b00, 2'b00, 2'b00, 2'b10}};
    pexp = '{8'h39, 8'h4F, 8'h66, 8'h80};

    tv[0] = '{1'b0, 2'b00, 1'b1, 1'b1, eo(1, 0, 8'h00, 0, 0, 1, 0)};
    for (int k = 0; k < 16; k++) begin
      int p;
      int b;
      p = k / 4;
      b = k % 4;
      tv[k+1] = '{1'b1, pin[p][b], 1'b1, 1'b0,
                  eo(k != 15, b == 3, (b == 3) ? pexp[p] : 8'h00,
                     (b == 3) ? p[1] : 1'b0, (b == 3) ? p[0] : 1'b0,
                     1, 0)};
    end
    tv[17] = '{1'b0, 2'b00, 1'b1, 1'b0, eo(0, 0, 8'h00, 0, 0, 1, 0)};
    tv[18] = '{1'b0, 2'b00, 1'b1, 1'b0, eo(0, 0, 8'h00, 0, 0, 1, 1)};
    tv[19] = '{1'b0, 2'b00, 1'b1, 1'b0, eo(0, 0, 8'h00, 0, 0, 0, 0)};

    rst = 1'b0; start = 1'b0; pe_en = 1'b0;
    pe_out = 2'b00; pix_ready = 1'b0;
    #12;
    chk("reset_outs", outs(), eo(0, 0, 8'h00, 0, 0, 0, 0));
`ifdef EC_OUT_PACKER_STATUS_EN
    chk("reset_status", {15'b0, ovf, drop_cnt}, 32'h0);
`endif
    rst = 1'b1;

    // Mid-frame reset after 5 beats, then a clean first pixel.
    step(0, 2'b00, 0, 1);
    chk("a_start", outs(), eo(1, 0, 8'h00, 0, 0, 1, 0));
    for (int b = 0; b < 4; b++) step(1, pin[0][b], 0, 0);
    step(1, pin[1][0], 0, 0);
    chk("a_pix0_held", outs(), eo(1, 1, 8'h39, 0, 0, 1, 0));
    async_reset("a_mid_reset");
    step(0, 2'b00, 1, 1);
    chk("a_restart", outs(), eo(1, 0, 8'h00, 0, 0, 1, 0));
    for (int b = 0; b < 3; b++) step(1, pin[0][b], 1, 0);
    chk("a_no_early", outs(), eo(1, 0, 8'h00, 0, 0, 1, 0));
    step(1, pin[0][3], 1, 0);
    chk("a_pix00", outs(), eo(1, 1, 8'h39, 0, 0, 1, 0));
    async_reset("a_reset2");

    // Full frame, continuous beats, no backpressure.
    for (int i = 0; i < 20; i++) begin
      step(tv[i].en, tv[i].po, tv[i].rdy, tv[i].st);
      chk($sformatf("frame_v%0d", i), outs(), tv[i].exp);
    end

    // Backpressure, dropped beat, ignored start, pop+push together.
    step(0, 2'b00, 0, 1);
    for (int k = 0; k < 8; k++) step(1, pin[k/4][k%4], 0, 0);
    chk("b_full", outs(), eo(0, 1, 8'h39, 0, 0, 1, 0));
    step(1, 2'b11, 0, 0);
    chk("b_drop", outs(), eo(0, 1, 8'h39, 0, 0, 1, 0));
`ifdef EC_OUT_PACKER_STATUS_EN
    chk("b_ovf", {15'b0, ovf, drop_cnt}, {15'b0, 1'b1, 16'd1});
`endif
    step(0, 2'b00, 1, 0);
    chk("b_pop1", outs(), eo(1, 1, 8'h4F, 0, 1, 1, 0));
    step(1, pin[2][0], 0, 0);
    step(1, pin[2][1], 0, 1);
    step(1, pin[2][2], 0, 0);
    step(1, pin[2][3], 0, 0);
    chk("b_refull", outs(), eo(0, 1, 8'h4F, 0, 1, 1, 0));
`ifdef EC_OUT_PACKER_STATUS_EN
    chk("b_start_ign", {15'b0, ovf, drop_cnt}, {15'b0, 1'b1, 16'd1});
`endif
    step(0, 2'b00, 1, 0);
    chk("b_pop2", outs(), eo(1, 1, 8'h66, 1, 0, 1, 0));
    for (int b = 0; b < 3; b++) begin
      step(1, pin[3][b], 0, 0);
      chk($sformatf("b_hold%0d", b), outs(),
          eo(1, 1, 8'h66, 1, 0, 1, 0));
    end
    step(1, pin[3][3], 1, 0);
    chk("b_pushpop", outs(), eo(0, 1, 8'h80, 1, 1, 1, 0));
    step(0, 2'b00, 1, 0);
    chk("b_drain", outs(), eo(0, 0, 8'h00, 0, 0, 1, 0));
    step(0, 2'b00, 1, 0);
    chk("b_done", outs(), eo(0, 0, 8'h00, 0, 0, 1, 1));
    step(0, 2'b00, 1, 0);
    chk("b_idle", outs(), eo(0, 0, 8'h00, 0, 0, 0, 0));
    step(0, 2'b00, 1, 1);
    chk("b_restart", outs(), eo(1, 0, 8'h00, 0, 0, 1, 0));
`ifdef EC_OUT_PACKER_STATUS_EN
    chk("b_status_clr", {15'b0, ovf, drop_cnt}, 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
